// File: rtl/myproject_sdiv_36s_6s_33_seq.sv
// Sequential signed divider: restoring division on operand magnitudes, one quotient
// bit per enabled cycle, sign fix-up applied when the result is registered.
module myproject_sdiv_36s_6s_33_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 36,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 33
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div0,
  output logic [1:0]            state_dbg
);

  // Handshake: operands are taken on a rising edge where ce=1, start=1 and busy=0;
  // results are valid in the cycle done=1 and hold until the next done.

  localparam int N0 = din0_WIDTH;
  localparam int N1 = din1_WIDTH;
  localparam int CW = $clog2(din0_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [N0-1:0] a_q;      // dividend bits shift out the top, quotient bits enter the bottom
  logic [N1-1:0] r_q;
  logic [N1-1:0] dvs_q;
  logic          qsign_q;
  logic          rsign_q;
  logic          zero_q;
  logic [N1-1:0] lo_q;
  logic [CW-1:0] cnt_q;

  logic [N0-1:0]         abs0;
  logic [N1-1:0]         abs1;
  logic [N1:0]           r_sh;
  logic [N1:0]           diff;
  logic                  borrow;
  logic [N1-1:0]         r_step;
  logic [N0-1:0]         a_step;
  logic [dout_WIDTH-1:0] q_low;
  logic [dout_WIDTH-1:0] q_fin;
  logic [N1-1:0]         r_fin;
  logic                  unused_id;

  assign unused_id = (ID == 0);

  always_comb begin
    abs0   = din0[N0-1] ? (~din0 + N0'(1)) : din0;
    abs1   = din1[N1-1] ? (~din1 + N1'(1)) : din1;
    r_sh   = {r_q, a_q[N0-1]};
    diff   = r_sh - {1'b0, dvs_q};
    borrow = diff[N1];
    r_step = borrow ? r_sh[N1-1:0] : diff[N1-1:0];
    a_step = {a_q[N0-2:0], ~borrow};
    // Low bits of a negation depend only on low bits, so the wrap is free.
    q_low  = a_q[dout_WIDTH-1:0];
    q_fin  = qsign_q ? (~q_low + dout_WIDTH'(1)) : q_low;
    r_fin  = rsign_q ? (~r_q + N1'(1)) : r_q;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    state_dbg = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_q == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= IDLE;
    end else if (ce) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      a_q     <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      zero_q  <= 1'b0;
      lo_q    <= '0;
      cnt_q   <= '0;
      done    <= 1'b0;
      dout    <= '0;
      rem     <= '0;
      div0    <= 1'b0;
    end else if (ce) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= abs0;
            r_q     <= '0;
            dvs_q   <= abs1;
            rsign_q <= din0[N0-1];
            qsign_q <= din0[N0-1] ^ din1[N1-1];
            zero_q  <= (din1 == '0);
            lo_q    <= din0[N1-1:0];
            cnt_q   <= CW'(din0_WIDTH);
          end
        end
        CALC: begin
          a_q   <= a_step;
          r_q   <= r_step;
          cnt_q <= cnt_q - CW'(1);
        end
        DONE: begin
          done <= 1'b1;
          div0 <= zero_q;
          if (zero_q) begin
            dout <= '1;
            rem  <= lo_q;
          end else begin
            dout <= q_fin;
            rem  <= r_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_myproject_sdiv_36s_6s_33_seq.sv
// Bench for the sequential signed divider: directed corner cases, ce stalls,
// reset abort, back-to-back and random operations against a longint model.
module tb_myproject_sdiv_36s_6s_33_seq;

  logic        ap_clk;
  logic        ap_rst;
  logic        ce;
  logic        start;
  logic [35:0] din0;
  logic [5:0]  din1;
  logic        busy;
  logic        done;
  logic [32:0] dout;
  logic [5:0]  rem;
  logic        div0;
  logic [1:0]  state_dbg;

  int checks;
  int failures;

  logic [32:0] exp_q[$];
  logic [5:0]  exp_rem_q[$];
  logic        exp_div0_q[$];

  myproject_sdiv_36s_6s_33_seq #(
    .ID(1), .din0_WIDTH(36), .din1_WIDTH(6), .dout_WIDTH(33)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .start(start),
    .din0(din0), .din1(din1), .busy(busy), .done(done),
    .dout(dout), .rem(rem), .div0(div0), .state_dbg(state_dbg)
  );

  // clock / reset
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  function automatic logic [32:0] model_q(input logic [35:0] a, input logic [5:0] b);
    longint sa, sb, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) q = -1;
    else q = sa / sb;
    return q[32:0];
  endfunction

  function automatic logic [5:0] model_r(input logic [35:0] a, input logic [5:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) r = sa;
    else r = sa % sb;
    return r[5:0];
  endfunction

  // driver: one-cycle start pulse, expectation pushed as operands are driven
  task automatic drive_start(input logic [35:0] a, input logic [5:0] b);
    @(negedge ap_clk);
    din0  = a;
    din1  = b;
    start = 1'b1;
    exp_q.push_back(model_q(a, b));
    exp_rem_q.push_back(model_r(a, b));
    exp_div0_q.push_back(b == 6'd0);
    @(posedge ap_clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge ap_clk);
      #1;
      lat++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    ce     = 1'b1;
    start  = 1'b0;
    din0   = '0;
    din1   = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== 33'd0 || rem !== 6'd0 || div0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b dout=%h rem=%h div0=%b required all zero",
               busy, done, dout, rem, div0);
    end
    @(negedge ap_clk);
    ap_rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [35:0] av[6];
    logic [5:0]  bv[6];
    logic [32:0] eq;
    logic [5:0]  er;
    logic        ez;
    int lat;
    av[0] = 36'd100;           bv[0] = 6'd7;
    av[1] = -36'sd100;         bv[1] = 6'd7;
    av[2] = 36'd100;           bv[2] = 6'b100000;
    av[3] = 36'h800000000;     bv[3] = 6'b111111;
    av[4] = 36'h800000000;     bv[4] = 6'b100000;
    av[5] = 36'd5;             bv[5] = 6'd0;
    for (int i = 0; i < 6; i++) begin
      drive_start(av[i], bv[i]);
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_after_start[%0d]: busy=%b required 1", i, busy);
      end
      wait_done(lat);
      eq = exp_q.pop_front();
      er = exp_rem_q.pop_front();
      ez = exp_div0_q.pop_front();
      checks++;
      if (lat !== 37) begin
        failures++;
        $display("FAIL latency[%0d]: got %0d required 37", i, lat);
      end
      checks++;
      if (dout !== eq || rem !== er || div0 !== ez) begin
        failures++;
        $display("FAIL result[%0d]: dout=%h rem=%h div0=%b required dout=%h rem=%h div0=%b",
                 i, dout, rem, div0, eq, er, ez);
      end
      @(posedge ap_clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || dout !== eq || rem !== er) begin
        failures++;
        $display("FAIL pulse_hold[%0d]: done=%b busy=%b dout=%h rem=%h required 0 0 %h %h",
                 i, done, busy, dout, rem, eq, er);
      end
    end
  endtask

  task automatic test_ce_stall();
    logic [32:0] eq;
    logic [5:0]  er;
    logic        ez;
    int lat;
    bit early;
    early = 1'b0;
    drive_start(36'd1234567, 6'b110111);
    lat = 0;
    repeat (15) begin
      @(posedge ap_clk); #1; lat++;
      if (done === 1'b1) early = 1'b1;
    end
    ce = 1'b0;
    repeat (10) begin
      @(posedge ap_clk); #1; lat++;
      if (done === 1'b1) early = 1'b1;
    end
    ce = 1'b1;
    @(negedge ap_clk);
    din0  = 36'd999;
    din1  = 6'd3;
    start = 1'b1;
    @(posedge ap_clk); #1; lat++;
    start = 1'b0;
    while (lat < 200 && done !== 1'b1) begin
      @(posedge ap_clk); #1; lat++;
    end
    eq = exp_q.pop_front();
    er = exp_rem_q.pop_front();
    ez = exp_div0_q.pop_front();
    checks++;
    if (early || lat !== 47) begin
      failures++;
      $display("FAIL ce_stall_latency: got %0d early=%b required 47 early=0", lat, early);
    end
    checks++;
    if (dout !== eq || rem !== er || div0 !== ez) begin
      failures++;
      $display("FAIL ce_stall_result: dout=%h rem=%h div0=%b required %h %h %b",
               dout, rem, div0, eq, er, ez);
    end
    @(posedge ap_clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL ignored_start: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_abort();
    logic [32:0] eq;
    logic [5:0]  er;
    logic        ez;
    int lat;
    bit seen;
    drive_start(36'd777777, 6'd13);
    repeat (20) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== 33'd0 || rem !== 6'd0 || div0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort_zero: busy=%b done=%b dout=%h rem=%h div0=%b required all zero",
               busy, done, dout, rem, div0);
    end
    void'(exp_q.pop_back());
    void'(exp_rem_q.pop_back());
    void'(exp_div0_q.pop_back());
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    seen = 1'b0;
    repeat (50) begin
      @(posedge ap_clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_no_done: activity=%b required 0", seen);
    end
    drive_start(-36'sd99999, 6'd11);
    wait_done(lat);
    eq = exp_q.pop_front();
    er = exp_rem_q.pop_front();
    ez = exp_div0_q.pop_front();
    checks++;
    if (lat !== 37 || dout !== eq || rem !== er || div0 !== ez) begin
      failures++;
      $display("FAIL after_reset_op: lat=%0d dout=%h rem=%h div0=%b required 37 %h %h %b",
               lat, dout, rem, div0, eq, er, ez);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] eq;
    logic [5:0]  er;
    logic        ez;
    logic [35:0] a;
    logic [5:0]  b;
    int lat;
    for (int i = 0; i < 10; i++) begin
      a = {$urandom_range(15, 0), $urandom()};
      b = 6'($urandom_range(63, 0));
      if (i == 3) b = 6'd0;
      if (i == 6) a = 36'h800000000;
      drive_start(a, b);
      wait_done(lat);
      eq = exp_q.pop_front();
      er = exp_rem_q.pop_front();
      ez = exp_div0_q.pop_front();
      checks++;
      if (lat !== 37 || dout !== eq || rem !== er || div0 !== ez) begin
        failures++;
        $display("FAIL b2b[%0d] a=%h b=%h: lat=%0d dout=%h rem=%h div0=%b required 37 %h %h %b",
                 i, a, b, lat, dout, rem, div0, eq, er, ez);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_ce_stall();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
